bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, processing one binary bit per clock. It replaces the purely combinational converter where N is large enough that an N-deep adder chain breaks timing. Valid/ready handshakes on input and output let it sit between streaming producers and display or formatting logic. An optional signed mode converts two's-complement input to sign plus BCD magnitude.

## Interface
- N, default 8: binary input width, legal range 2 to 64.
- SIGNED, default 0: 0 means `in_data` is unsigned; 1 means `in_data` is two's complement.
- D, derived, not overridable: BCD digit count, `D = ((N*1233) >> 12) + 1`. Gives 3 for N=8, 5 for N=16, 10 for N=32.
- `clk`, input, 1 bit: single clock, all state updates on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `in_valid`, input, 1 bit: `in_data` is valid this cycle.
- `in_ready`, output, 1 bit: the block accepts `in_data` this cycle.
- `in_data`, input, N bits: value to convert.
- `out_valid`, output, 1 bit: `out_bcd` and `out_neg` hold a result.
- `out_ready`, input, 1 bit: the consumer takes the result this cycle.
- `out_bcd`, output, 4*D bits: packed BCD; digit 0 is in [3:0] and is the least significant.
- `out_neg`, output, 1 bit: result is negative; always 0 when SIGNED=0.
- `busy`, output, 1 bit: a conversion is in progress (SHIFT state).

## Operation
- State machine states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: load the magnitude register with `in_data`, or with |`in_data`| when SIGNED=1.
  - Set the sign flag to `in_data[N-1]`, or to 0 when SIGNED=0.
  - Clear the BCD register, set the bit counter to N, go to SHIFT.
- SHIFT, one step per cycle:
  - Each digit ≥5 gets +3 (mod 16 per digit).
  - Then {BCD, magnitude} shifts left 1; the magnitude MSB enters digit 0 bit 0.
  - Decrement the counter; when it reaches 1, the last step completes and the state goes to DONE.
- DONE:
  - `out_valid`=1; `out_bcd` and `out_neg` are stable until handshake.
  - On `out_ready`, go to IDLE.
  - If `in_valid` is also high in that cycle, load the new operand and go straight to SHIFT (back-to-back).
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). It is combinational, with no dependency on `in_valid`.
- Magnitude arithmetic:
  - Computed as (~`in_data`+1) in N bits, treated as unsigned.
  - −2^(N−1) maps to 2^(N−1) and needs no extra bit.
  - `out_neg`=1 only if the input is negative; a zero input gives `out_neg`=0.
- `in_valid` while not ready is ignored and nothing is latched. The producer must hold its data.
- Reset mid-conversion:
  - State returns to IDLE and the partial result is discarded.
  - No `out_valid` pulse appears for the aborted operand.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_bcd`=0, `out_neg`=0, `busy`=0.
- `in_ready` is 1 once reset completes. Inputs are ignored while `rst` is high.
- Latency: operand accepted at edge k gives `out_valid`=1 after edge k+N. This is N cycles in SHIFT.
- Throughput with `out_ready` held at 1: one result per N+1 cycles.
- `busy` is high exactly N cycles per conversion.
- Outputs are registered; `out_bcd` changes only on the transition from SHIFT to DONE.

## Structure
- Package `bin2bcd_pkg` contains:
  - function `bcd_digits(n)`, which returns ((n*1233)>>12)+1;
  - the state enum `bcd_state_t` {IDLE, SHIFT, DONE};
  - localparam `DIGIT_W`=4.
- Sub-module `bcd_digit_adj`: combinational, 4-bit in, 4-bit out, returns (d≥5 ? d+3 : d). It is instantiated D times by generate.
- Top-level registers: magnitude, BCD, counter of $clog2(N+1) bits, sign flag, state.

## Test plan
- Unsigned max: N=8, SIGNED=0, input 255 → after 8 cycles `out_bcd`=12'h255, `out_neg`=0; `busy` high for exactly 8 cycles.
- Zero and power of ten:
  - N=16, input 0 → 20'h00000.
  - N=16, input 10000 → 20'h10000.
  - N=16, input 65535 → 20'h65535.
- Signed extremes, N=8, SIGNED=1:
  - −128 (8'h80) → `out_bcd`=12'h128, `out_neg`=1.
  - −1 → 12'h001, `out_neg`=1.
  - 127 → 12'h127, `out_neg`=0.
- Backpressure: hold `out_ready`=0 for 20 cycles after DONE.
  - `out_valid` and `out_bcd` must stay stable and `in_ready`=0 throughout.
  - A pending `in_valid` is not accepted until `out_ready`=1.
- Back-to-back: N=8, `in_valid` and `out_ready` both held high with inputs 42 then 99.
  - Results 12'h042 then 12'h099, 9 cycles apart.
  - No lost or duplicated result.
- Reset mid-operation: assert `rst` asynchronously in the 4th SHIFT cycle.
  - All outputs go to reset values immediately and no `out_valid` appears.
  - The next operand, 200, converts to 12'h200.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   bcd_digits(n) : number of BCD digits needed for an n-bit unsigned value
//   bcd_state_t   : converter FSM states
//   DIGIT_W       : width of one BCD digit
package bin2bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // 1233/4096 approximates log10(2); the +1 covers the fractional digit.
  function automatic int bcd_digits(input int n);
    return ((n * 1233) >> 12) + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decade.
//   digit_i : BCD digit before the shift step
//   digit_o : corrected digit (mod 16)
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  // add-3 correction for digits at or above 5
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake, in_data is the N-bit operand
//   out_valid/out_ready : result handshake
//   out_bcd             : packed BCD result, digit 0 in [3:0]
//   out_neg             : result is negative (SIGNED=1 only)
//   busy                : conversion in progress
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int N      = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N-1:0]                       in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DIGIT_W*bcd_digits(N)-1:0]   out_bcd,
  output logic                               out_neg,
  output logic                               busy
);

  localparam int D  = bcd_digits(N);
  localparam int BW = DIGIT_W * D;
  localparam int CW = $clog2(N + 1);

  bcd_state_t     state_q;
  logic [N-1:0]   mag_q;
  logic [BW-1:0]  bcd_q;
  logic [CW-1:0]  cnt_q;
  logic           sign_q;
  logic [BW-1:0]  out_bcd_q;
  logic           out_neg_q;
  logic           out_valid_q;
  logic           busy_q;

  logic [BW-1:0]  adj_s;
  logic [BW-1:0]  bcd_d;
  logic [N-1:0]   mag_d;
  logic [N-1:0]   mag_load_d;
  logic           sign_load_d;
  logic           in_ready_s;
  logic           load_s;

  for (genvar g = 0; g < D; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (adj_s[g*DIGIT_W +: DIGIT_W])
    );
  end

  // magnitude and sign of the incoming operand
  always_comb begin
    mag_load_d  = in_data;
    sign_load_d = 1'b0;
    if ((SIGNED != 1'b0) && in_data[N-1]) begin
      // -2^(N-1) wraps to 2^(N-1), which still fits as an unsigned N-bit value
      mag_load_d  = ~in_data + N'(1);
      sign_load_d = 1'b1;
    end else begin
      mag_load_d  = in_data;
      sign_load_d = 1'b0;
    end
  end

  // one double-dabble step: corrected BCD shifts left taking the magnitude MSB
  always_comb begin
    bcd_d = (adj_s << 1) | {{(BW-1){1'b0}}, mag_q[N-1]};
    mag_d = mag_q << 1;
  end

  // handshake decode
  always_comb begin
    in_ready_s = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    load_s     = in_ready_s & in_valid;
  end

  // converter FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      out_bcd_q   <= '0;
      out_neg_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            out_bcd_q   <= bcd_d;
            out_neg_q   <= sign_q;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
      // A load (from IDLE, or back-to-back out of DONE) overrides the
      // state chosen above.
      if (load_s) begin
        mag_q   <= mag_load_d;
        sign_q  <= sign_load_d;
        bcd_q   <= '0;
        cnt_q   <= CW'(N);
        busy_q  <= 1'b1;
        state_q <= SHIFT;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_neg   = out_neg_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // instance A: N=8 unsigned
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_neg, a_busy;
  logic [7:0]  a_in_data;
  logic [11:0] a_out_bcd;
  // instance B: N=16 unsigned
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_neg, b_busy;
  logic [15:0] b_in_data;
  logic [19:0] b_out_bcd;
  // instance C: N=8 signed
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_neg, c_busy;
  logic [7:0]  c_in_data;
  logic [11:0] c_out_bcd;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];
  int          a_hs[$];
  int          a_nres = 0;

  bin2bcd_seq #(.N(8), .SIGNED(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_bcd(a_out_bcd), .out_neg(a_out_neg), .busy(a_busy));

  bin2bcd_seq #(.N(16), .SIGNED(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_bcd(b_out_bcd), .out_neg(b_out_neg), .busy(b_busy));

  bin2bcd_seq #(.N(8), .SIGNED(1'b1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_bcd(c_out_bcd), .out_neg(c_out_neg), .busy(c_busy));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic n, input logic [19:0] b);
    return {7'd0, n, 4'd0, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitors: compare on each completed output handshake
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      chk("a_result", mk(a_out_neg, {8'd0, a_out_bcd}),
          (qa.size() > 0) ? qa.pop_front() : 32'hFFFF_FFFF);
      a_hs.push_back(cyc);
      a_nres++;
    end
    if (!rst && b_out_valid && b_out_ready) begin
      chk("b_result", mk(b_out_neg, b_out_bcd),
          (qb.size() > 0) ? qb.pop_front() : 32'hFFFF_FFFF);
    end
    if (!rst && c_out_valid && c_out_ready) begin
      chk("c_result", mk(c_out_neg, {8'd0, c_out_bcd}),
          (qc.size() > 0) ? qc.pop_front() : 32'hFFFF_FFFF);
    end
  end

  task automatic conv_b(input logic [15:0] d, input logic [19:0] e);
    int i;
    b_in_data  = d;
    b_in_valid = 1'b1;
    qb.push_back(mk(1'b0, e));
    tick();
    b_in_valid = 1'b0;
    i = 0;
    while (qb.size() != 0 && i < 60) begin
      tick();
      i++;
    end
    chk("b_drain", qb.size(), 0);
  endtask

  task automatic conv_c(input logic [7:0] d, input logic n, input logic [11:0] e);
    int i;
    c_in_data  = d;
    c_in_valid = 1'b1;
    qc.push_back(mk(n, {8'd0, e}));
    tick();
    c_in_valid = 1'b0;
    i = 0;
    while (qc.size() != 0 && i < 40) begin
      tick();
      i++;
    end
    chk("c_drain", qc.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_cnt;
    int vcnt;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 8'd0;  a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 16'd0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = 8'd0;  c_out_ready = 1'b1;
    tick();
    tick();
    chk("rst_a_valid", a_out_valid, 1'b0);
    chk("rst_a_bcd", a_out_bcd, 12'h000);
    chk("rst_a_neg", a_out_neg, 1'b0);
    chk("rst_a_busy", a_busy, 1'b0);
    chk("rst_b_busy", b_busy, 1'b0);
    chk("rst_c_busy", c_busy, 1'b0);
    rst = 1'b0;
    tick();
    chk("a_in_ready_idle", a_in_ready, 1'b1);
    chk("b_in_ready_idle", b_in_ready, 1'b1);
    chk("c_in_ready_idle", c_in_ready, 1'b1);

    // 255: latency and busy length
    a_in_data  = 8'd255;
    a_in_valid = 1'b1;
    qa.push_back(mk(1'b0, 20'h00255));
    tick();
    a_in_valid = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!a_out_valid && n < 40) begin
      if (a_busy) busy_cnt++;
      tick();
      n++;
    end
    chk("a_latency", n, 8);
    chk("a_busy_cycles", busy_cnt, 8);

    // backpressure with a pending operand
    a_in_data  = 8'd42;
    a_in_valid = 1'b1;
    qa.push_back(mk(1'b0, 20'h00042));
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp_valid", a_out_valid, 1'b1);
      chk("bp_bcd", a_out_bcd, 12'h255);
      chk("bp_in_ready", a_in_ready, 1'b0);
      chk("bp_not_accepted", a_busy, 1'b0);
    end

    // release: 255 handed off, 42 accepted, then 99 back-to-back
    a_out_ready = 1'b1;
    tick();
    a_in_data = 8'd99;
    qa.push_back(mk(1'b0, 20'h00099));
    n = 0;
    while (qa.size() != 1 && n < 40) begin
      tick();
      n++;
    end
    a_in_valid = 1'b0;
    n = 0;
    while (qa.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk("a_nres", a_nres, 3);
    chk("a_gap_42", (a_hs.size() >= 2) ? a_hs[1] - a_hs[0] : -1, 9);
    chk("a_gap_99", (a_hs.size() >= 3) ? a_hs[2] - a_hs[1] : -1, 9);

    // 16-bit unsigned
    conv_b(16'd0,     20'h00000);
    conv_b(16'd10000, 20'h10000);
    conv_b(16'd65535, 20'h65535);
    conv_b(16'd12345, 20'h12345);

    // 8-bit signed
    conv_c(8'h80, 1'b1, 12'h128);
    conv_c(8'hFF, 1'b1, 12'h001);
    conv_c(8'h7F, 1'b0, 12'h127);
    conv_c(8'h00, 1'b0, 12'h000);
    conv_c(8'h9C, 1'b1, 12'h100);

    // reset during the 4th SHIFT cycle of instance A
    a_in_data  = 8'd77;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", a_out_valid, 1'b0);
    chk("arst_busy", a_busy, 1'b0);
    chk("arst_bcd", a_out_bcd, 12'h000);
    chk("arst_neg", a_out_neg, 1'b0);
    chk("arst_in_ready", a_in_ready, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (a_out_valid) vcnt++;
    end
    chk("arst_no_valid", vcnt, 0);

    a_in_data  = 8'd200;
    a_in_valid = 1'b1;
    qa.push_back(mk(1'b0, 20'h00200));
    tick();
    a_in_valid = 1'b0;
    n = 0;
    while (qa.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk("a_drain_200", qa.size(), 0);
    chk("a_nres_final", a_nres, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
